ncap_intr_deliver: RTL
======================

// Module: ncap_intr_deliver
// PURPOSE
//  Host-side delivery end of the NCAP interrupt path. Accepts 1-cycle interrupt pulses and
//  their 2-bit type from the NCAP traffic controller, issues one MSI request per event with a
//  req/ack handshake, and exposes the delivered type in a host-readable status latch.
//  Enforces a runtime hold-off between interrupts. Coalesces events that arrive while busy
//  into a single pending slot (latest type wins).
// PARAMETERS
//  VEC_BASE      5'd0        MSI vector of type 0; vector = VEC_BASE + type
//  CLR_TIMEOUT   1_000_000   cycles in WAIT_CLR before auto-clear; >= 1
//  HOLDOFF_W     16          width of holdoff_cycles input
// PORTS
//  clk             in   1         clock
//  rst             in   1         synchronous reset, active-low (0 = reset)
//  intr_in         in   1         event pulse from NCAP controller
//  intr_type_in    in   2         event type, valid with intr_in ([0] high-perf, [1] speculative)
//  holdoff_cycles  in   HOLDOFF_W minimum idle gap after each clear, from OS register
//  msi_req         out  1         MSI request to PCIe core, held until msi_ack
//  msi_vector      out  5         vector, stable while msi_req=1
//  msi_ack         in   1         PCIe core accepts request
//  host_clr        in   1         1-cycle host write-1-to-clear of the status latch
//  status_pending  out  1         delivered interrupt not yet cleared
//  status_type     out  2         type of last delivered interrupt
//  busy            out  1         state != IDLE
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE; msi_req=0, msi_vector=VEC_BASE, status_pending=0,
//   status_type=0, pend=0, all counters 0. Reset mid-request drops msi_req on that edge; event lost.
//  States: IDLE -> REQ -> WAIT_CLR -> HOLDOFF -> (REQ | IDLE).
//  IDLE: intr_in=1 -> cur_type<=intr_type_in, msi_req<=1, msi_vector<=VEC_BASE+intr_type_in,
//   go REQ. Latency intr_in -> msi_req = 1 cycle.
//  REQ: msi_req held high, vector stable. msi_ack=1 at edge -> msi_req<=0, status_pending<=1,
//   status_type<=cur_type, go WAIT_CLR. No ack -> wait indefinitely.
//  WAIT_CLR: timeout counter from 0. host_clr=1 -> status_pending<=0, go HOLDOFF. Counter
//   reaches CLR_TIMEOUT-1 without clr -> same exit (auto-clear). Holdoff counter loads
//   holdoff_cycles on exit.
//  HOLDOFF: counts down 1/cycle; holdoff_cycles=0 -> exits on first HOLDOFF cycle. At zero:
//   intr_in=1 -> REQ with intr_type_in (overrides pend; pend cleared, coalesced if pend was 1);
//   else pend=1 -> REQ with pend_type, pend<=0; else IDLE.
//  Pending slot: intr_in=1 in REQ/WAIT_CLR/HOLDOFF (except HOLDOFF exit cycle) -> pend<=1,
//   pend_type<=intr_type_in; if pend already 1, event coalesced (overwrite).
//  Ignored inputs: msi_ack outside REQ; host_clr outside WAIT_CLR; intr_type_in without intr_in.
//  host_clr and timeout on same cycle: one exit, counted as clear (not timeout).
//  Vector add is 5-bit modulo (wraps past 31). busy combinational from state.
// CONFIGURATION
//  NCAP_INTR_STATS_EN defined: adds outputs stat_delivered, stat_coalesced, stat_timeout
//   (32 each): delivered++ on each REQ ack; coalesced++ per overwritten pending event;
//   timeout++ per auto-clear. Saturate at 32'hFFFF_FFFF; reset to 0.
//  Undefined: ports and counters absent; other behaviour identical.
// TESTING
//  1 intr_in, type=2'b01, VEC_BASE=4, ack 3 cycles after req -> msi_req 1 cycle after pulse,
//    vector=5, held 3 cycles; status_pending=1, status_type=01.
//  2 host_clr, holdoff_cycles=10, no new events -> IDLE 11 cycles after clr; busy=0.
//  3 types 00,10,11 pulsed during WAIT_CLR -> one more MSI after holdoff, vector=VEC_BASE+3;
//    stat_coalesced=2, stat_delivered=2.
//  4 no host_clr, CLR_TIMEOUT=100 -> status_pending drops 100 cycles after ack; stat_timeout=1.
//  5 rst=0 while msi_req=1 -> next edge msi_req=0, status_pending=0, pend=0; later ack ignored.
//  6 holdoff_cycles=0 plus intr_in on HOLDOFF exit cycle -> immediate REQ with that type.

Source files
------------

// File: rtl/ncap_intr_deliver_if.sv
// Event, MSI handshake and host status signals of the NCAP interrupt delivery block.
//  slave  : view used by ncap_intr_deliver
//  master : view used by the traffic controller / PCIe core / host side (or a bench)
//  Event    : intr_in, intr_type_in, holdoff_cycles
//  MSI      : msi_req, msi_vector, msi_ack
//  Host     : host_clr, status_pending, status_type, busy
interface ncap_intr_deliver_if #(
  parameter int unsigned HOLDOFF_W = 16
);
  logic                 intr_in;
  logic [1:0]           intr_type_in;
  logic [HOLDOFF_W-1:0] holdoff_cycles;
  logic                 msi_req;
  logic [4:0]           msi_vector;
  logic                 msi_ack;
  logic                 host_clr;
  logic                 status_pending;
  logic [1:0]           status_type;
  logic                 busy;

  modport slave (
    input  intr_in, intr_type_in, holdoff_cycles, msi_ack, host_clr,
    output msi_req, msi_vector, status_pending, status_type, busy
  );

  modport master (
    output intr_in, intr_type_in, holdoff_cycles, msi_ack, host_clr,
    input  msi_req, msi_vector, status_pending, status_type, busy
  );
endinterface

// File: rtl/ncap_intr_deliver.sv
// Host-side delivery of NCAP interrupts: one MSI per event via req/ack, host-readable
// status latch with write-1-to-clear or auto-clear timeout, runtime hold-off between
// interrupts and a single coalescing pending slot (latest type wins).
// Ports:
//  clk                clock
//  rst                synchronous reset, active-low
//  bus                ncap_intr_deliver_if.slave (event in, MSI out, host status)
//  stat_delivered     [NCAP_INTR_STATS_EN] saturating count of acked MSIs
//  stat_coalesced     [NCAP_INTR_STATS_EN] saturating count of overwritten pending events
//  stat_timeout       [NCAP_INTR_STATS_EN] saturating count of auto-clears
// Optional feature macro: NCAP_INTR_STATS_EN (statistics counters and their ports).
module ncap_intr_deliver #(
  parameter logic [4:0]  VEC_BASE    = 5'd0,
  parameter int unsigned CLR_TIMEOUT = 1_000_000,
  parameter int unsigned HOLDOFF_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  ncap_intr_deliver_if.slave  bus
`ifdef NCAP_INTR_STATS_EN
  ,
  output logic [31:0]         stat_delivered,
  output logic [31:0]         stat_coalesced,
  output logic [31:0]         stat_timeout
`endif
);

  localparam int unsigned TMO_W = (CLR_TIMEOUT > 1) ? $clog2(CLR_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CLR_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_CLR = 2'd2,
    HOLDOFF  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 msi_req_q, msi_req_d;
  logic [4:0]           vec_q, vec_d;
  logic [1:0]           cur_type_q, cur_type_d;
  logic                 status_pending_q, status_pending_d;
  logic [1:0]           status_type_q, status_type_d;
  logic                 pend_q, pend_d;
  logic [1:0]           pend_type_q, pend_type_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;

  logic                 holdoff_exit;
  logic                 load_req;
  logic [1:0]           load_type;

  assign holdoff_exit = (state_q == HOLDOFF) && (hold_cnt_q == '0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      msi_req_q        <= 1'b0;
      vec_q            <= VEC_BASE;
      cur_type_q       <= 2'b00;
      status_pending_q <= 1'b0;
      status_type_q    <= 2'b00;
      pend_q           <= 1'b0;
      pend_type_q      <= 2'b00;
      tmo_cnt_q        <= '0;
      hold_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      msi_req_q        <= msi_req_d;
      vec_q            <= vec_d;
      cur_type_q       <= cur_type_d;
      status_pending_q <= status_pending_d;
      status_type_q    <= status_type_d;
      pend_q           <= pend_d;
      pend_type_q      <= pend_type_d;
      tmo_cnt_q        <= tmo_cnt_d;
      hold_cnt_q       <= hold_cnt_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d          = state_q;
    msi_req_d        = msi_req_q;
    vec_d            = vec_q;
    cur_type_d       = cur_type_q;
    status_pending_d = status_pending_q;
    status_type_d    = status_type_q;
    pend_d           = pend_q;
    pend_type_d      = pend_type_q;
    tmo_cnt_d        = tmo_cnt_q;
    hold_cnt_d       = hold_cnt_q;
    load_req         = 1'b0;
    load_type        = 2'b00;

    // Events while busy land in the pending slot; the hold-off exit cycle consumes
    // intr_in directly instead.
    if (bus.intr_in && (state_q != IDLE) && !holdoff_exit) begin
      pend_d      = 1'b1;
      pend_type_d = bus.intr_type_in;
    end

    case (state_q)
      IDLE: begin
        if (bus.intr_in) begin
          load_req  = 1'b1;
          load_type = bus.intr_type_in;
        end
      end
      REQ: begin
        if (bus.msi_ack) begin
          msi_req_d        = 1'b0;
          status_pending_d = 1'b1;
          status_type_d    = cur_type_q;
          tmo_cnt_d        = '0;
          state_d          = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (bus.host_clr || (tmo_cnt_q == TMO_LAST)) begin
          status_pending_d = 1'b0;
          hold_cnt_d       = bus.holdoff_cycles;
          state_d          = HOLDOFF;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          pend_d = 1'b0;
          if (bus.intr_in) begin
            load_req  = 1'b1;
            load_type = bus.intr_type_in;
          end else if (pend_q) begin
            load_req  = 1'b1;
            load_type = pend_type_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Launch a new MSI; vector add wraps modulo 32.
    if (load_req) begin
      state_d    = REQ;
      msi_req_d  = 1'b1;
      vec_d      = VEC_BASE + 5'(load_type);
      cur_type_d = load_type;
    end
  end

  assign bus.msi_req        = msi_req_q;
  assign bus.msi_vector     = vec_q;
  assign bus.status_pending = status_pending_q;
  assign bus.status_type    = status_type_q;
  assign bus.busy           = (state_q != IDLE);

`ifdef NCAP_INTR_STATS_EN
  logic        deliver_ev, coal_ev, tmo_ev;
  logic [31:0] stat_deliv_q, stat_coal_q, stat_tmo_q;

  // A coalesce is any event arriving while the pending slot is already occupied,
  // including one that overrides the slot on the hold-off exit cycle.
  assign deliver_ev = (state_q == REQ) && bus.msi_ack;
  assign coal_ev    = bus.intr_in && pend_q && (state_q != IDLE);
  assign tmo_ev     = (state_q == WAIT_CLR) && !bus.host_clr && (tmo_cnt_q == TMO_LAST);

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_deliv_q <= '0;
      stat_coal_q  <= '0;
      stat_tmo_q   <= '0;
    end else begin
      if (deliver_ev && (stat_deliv_q != '1)) stat_deliv_q <= stat_deliv_q + 32'd1;
      if (coal_ev && (stat_coal_q != '1))     stat_coal_q  <= stat_coal_q + 32'd1;
      if (tmo_ev && (stat_tmo_q != '1))       stat_tmo_q   <= stat_tmo_q + 32'd1;
    end
  end

  assign stat_delivered = stat_deliv_q;
  assign stat_coalesced = stat_coal_q;
  assign stat_timeout   = stat_tmo_q;
`endif

endmodule
